image_feeder: RTL and testbench

IMAGE_FEEDER -- requirements
Module: image_feeder

---
 rtl/image_feeder_pkg.sv | 30 +++
 rtl/image_feeder_chunk_streamer.sv | 67 ++++++
 rtl/image_feeder.sv | 148 ++++++++++++++
 tb/tb_image_feeder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_feeder_pkg.sv
// Shared types for the image feeder and its chunk streamer:
// pixel format, feeder state encoding and sizing helpers.
package image_feeder_pkg;

  localparam int FP_W = 16;

  typedef logic signed [FP_W-1:0] fixed_point;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    STREAM,
    WAIT_LABEL,
    NEXT,
    DONE
  } feeder_state_t;

  function automatic int chunks_f(
    input int num_pixels,
    input int input_size
  );
    return (num_pixels + input_size - 1) / input_size;
  endfunction

  // Keeps single-value ranges at one bit instead of zero.
  function automatic int width_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_feeder_chunk_streamer.sv
// Walks the ROM words of one image, one chunk per cycle,
// running the address one word ahead and zeroing pad lanes.
module image_feeder_chunk_streamer
  import image_feeder_pkg::*;
#(
  parameter int INPUT_SIZE = 1,
  parameter int NUM_PIXELS = 784,
  parameter int NUM_IMAGES = 100,
  localparam int CHUNKS = chunks_f(NUM_PIXELS, INPUT_SIZE),
  localparam int ADDR_W = width_f(NUM_IMAGES * CHUNKS),
  localparam int IMG_W  = width_f(NUM_IMAGES)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         active_i,
  input  logic       [IMG_W-1:0]       image_num_i,
  output logic       [ADDR_W-1:0]      rom_addr_o,
  input  fixed_point [INPUT_SIZE-1:0]  rom_data_i,
  output fixed_point [INPUT_SIZE-1:0]  pixels_o,
  output logic                         last_o
);

  localparam int K_W = width_f(CHUNKS);
  localparam int LAST_LANES =
    NUM_PIXELS - (CHUNKS - 1) * INPUT_SIZE;
  localparam logic [K_W-1:0] K_LAST = K_W'(CHUNKS - 1);

  logic [K_W-1:0]    k_q;
  logic [K_W-1:0]    k_d;
  logic [ADDR_W-1:0] base;

  assign base = ADDR_W'(image_num_i) * ADDR_W'(CHUNKS);
  assign last_o = active_i && (k_q == K_LAST);

  always_comb begin
    k_d = '0;
    if (active_i && !last_o) begin
      k_d = k_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  // Address leads the data by one word to cover ROM latency.
  always_comb begin
    rom_addr_o = base;
    if (active_i) begin
      rom_addr_o = base + ADDR_W'(k_q) + 1'b1;
    end
  end

  always_comb begin
    pixels_o = '0;
    for (int l = 0; l < INPUT_SIZE; l++) begin
      if (active_i && !(last_o && l >= LAST_LANES)) begin
        pixels_o[l] = rom_data_i[l];
      end
    end
  end

endmodule

// File: rtl/image_feeder.sv
// Streams a run of images from ROM into a classifier and
// scores the returned labels, with a per-image watchdog.
module image_feeder
  import image_feeder_pkg::*;
#(
  parameter int INPUT_SIZE  = 1,
  parameter int NUM_PIXELS  = 784,
  parameter int NUM_IMAGES  = 100,
  parameter int NUM_CLASSES = 10,
  parameter int TIMEOUT     = 4096,
  localparam int CHUNKS = chunks_f(NUM_PIXELS, INPUT_SIZE),
  localparam int ADDR_W = width_f(NUM_IMAGES * CHUNKS),
  localparam int IMG_W  = width_f(NUM_IMAGES),
  localparam int LBL_W  = width_f(NUM_CLASSES),
  localparam int CNT_W  = width_f(NUM_IMAGES + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic       [ADDR_W-1:0]      rom_addr,
  input  fixed_point [INPUT_SIZE-1:0]  rom_data,
  output logic                         image_ready,
  output fixed_point [INPUT_SIZE-1:0]  pixels,
  input  logic       [LBL_W-1:0]       label,
  input  logic                         label_ready,
  output logic       [IMG_W-1:0]       image_num,
  input  logic       [LBL_W-1:0]       expected_label,
  output logic       [CNT_W-1:0]       correct_count,
  output logic       [CNT_W-1:0]       timeout_count,
  output logic                         busy,
  output logic                         done
);

  localparam int WD_W = width_f(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [IMG_W-1:0] IMG_LAST =
    IMG_W'(NUM_IMAGES - 1);

  feeder_state_t    state_q;
  feeder_state_t    state_d;
  logic [IMG_W-1:0] img_q;
  logic [IMG_W-1:0] img_d;
  logic [CNT_W-1:0] correct_q;
  logic [CNT_W-1:0] correct_d;
  logic [CNT_W-1:0] timeout_q;
  logic [CNT_W-1:0] timeout_d;
  logic [WD_W-1:0]  wd_q;
  logic [WD_W-1:0]  wd_d;
  logic             streaming;
  logic             last_chunk;

  assign streaming = (state_q == STREAM);

  image_feeder_chunk_streamer #(
    .INPUT_SIZE (INPUT_SIZE),
    .NUM_PIXELS (NUM_PIXELS),
    .NUM_IMAGES (NUM_IMAGES)
  ) u_chunk_streamer (
    .clock       (clock),
    .reset       (reset),
    .active_i    (streaming),
    .image_num_i (img_q),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .pixels_o    (pixels),
    .last_o      (last_chunk)
  );

  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    correct_d   = correct_q;
    timeout_d   = timeout_q;
    wd_d        = '0;
    image_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          img_d     = '0;
          correct_d = '0;
          timeout_d = '0;
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        busy        = 1'b1;
        image_ready = 1'b1;
        state_d     = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_d = WAIT_LABEL;
        end
      end
      WAIT_LABEL: begin
        busy = 1'b1;
        wd_d = wd_q + 1'b1;
        // A label in the expiry cycle still counts as an answer.
        if (label_ready) begin
          if (label == expected_label) begin
            correct_d = correct_q + 1'b1;
          end
          state_d = NEXT;
        end else if (wd_q == WD_LAST) begin
          timeout_d = timeout_q + 1'b1;
          state_d   = NEXT;
        end
      end
      NEXT: begin
        busy = 1'b1;
        if (img_q == IMG_LAST) begin
          state_d = DONE;
        end else begin
          img_d   = img_q + 1'b1;
          state_d = REQUEST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      img_q     <= '0;
      correct_q <= '0;
      timeout_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      img_q     <= img_d;
      correct_q <= correct_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  assign image_num     = img_q;
  assign correct_count = correct_q;
  assign timeout_count = timeout_q;

endmodule

// File: tb/tb_image_feeder.sv
// Directed bench for image_feeder: three parameterisations
// sharing one clock and reset, each with its own ROM.
module tb_image_feeder;
  import image_feeder_pkg::*;

  logic clock;
  logic reset;
  int   pass;
  int   total;

  // A: 10 pixels, 1 lane, 2 images
  logic             start_a, ir_a, lr_a, busy_a, done_a;
  logic [4:0]       addr_a;
  fixed_point [0:0] rom_a, pix_a;
  logic [3:0]       lbl_a, exp_a;
  logic [0:0]       img_a;
  logic [1:0]       cor_a, to_a;

  // B: 10 pixels, 4 lanes, 2 images
  logic             start_b, ir_b, lr_b, busy_b, done_b;
  logic [2:0]       addr_b;
  fixed_point [3:0] rom_b, pix_b;
  logic [3:0]       lbl_b, exp_b;
  logic [0:0]       img_b;
  logic [1:0]       cor_b, to_b;

  // C: 10 pixels, 1 lane, 3 images, timeout 8
  logic             start_c, ir_c, lr_c, busy_c, done_c;
  logic [4:0]       addr_c;
  fixed_point [0:0] rom_c, pix_c;
  logic [3:0]       lbl_c, exp_c;
  logic [1:0]       img_c;
  logic [1:0]       cor_c, to_c;

  image_feeder #(
    .INPUT_SIZE(1), .NUM_PIXELS(10), .NUM_IMAGES(2),
    .NUM_CLASSES(10), .TIMEOUT(64)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .rom_addr(addr_a), .rom_data(rom_a),
    .image_ready(ir_a), .pixels(pix_a),
    .label(lbl_a), .label_ready(lr_a),
    .image_num(img_a), .expected_label(exp_a),
    .correct_count(cor_a), .timeout_count(to_a),
    .busy(busy_a), .done(done_a)
  );

  image_feeder #(
    .INPUT_SIZE(4), .NUM_PIXELS(10), .NUM_IMAGES(2),
    .NUM_CLASSES(10), .TIMEOUT(64)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .rom_addr(addr_b), .rom_data(rom_b),
    .image_ready(ir_b), .pixels(pix_b),
    .label(lbl_b), .label_ready(lr_b),
    .image_num(img_b), .expected_label(exp_b),
    .correct_count(cor_b), .timeout_count(to_b),
    .busy(busy_b), .done(done_b)
  );

  image_feeder #(
    .INPUT_SIZE(1), .NUM_PIXELS(10), .NUM_IMAGES(3),
    .NUM_CLASSES(10), .TIMEOUT(8)
  ) dut_c (
    .clock(clock), .reset(reset), .start(start_c),
    .rom_addr(addr_c), .rom_data(rom_c),
    .image_ready(ir_c), .pixels(pix_c),
    .label(lbl_c), .label_ready(lr_c),
    .image_num(img_c), .expected_label(exp_c),
    .correct_count(cor_c), .timeout_count(to_c),
    .busy(busy_c), .done(done_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROMs: word n = n (A, C); lane l of word n = 4n+l (B)
  always_ff @(posedge clock) begin
    rom_a[0] <= 16'(addr_a);
    rom_c[0] <= 16'(addr_c);
    for (int l = 0; l < 4; l++) begin
      rom_b[l] <= 16'({addr_b, 2'(l)});
    end
  end

  // Label tables: A 3,4  B 5,6  C 1,2,3
  assign exp_a = {3'b0, img_a} + 4'd3;
  assign exp_b = {3'b0, img_b} + 4'd5;
  assign exp_c = {2'b0, img_c} + 4'd1;

  function automatic logic [63:0] lanes4(input int a, input int n);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < n; l++) v[16*l +: 16] = 16'(4*a + l);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_a = 0; lr_a = 0; lbl_a = 0;
    start_b = 0; lr_b = 0; lbl_b = 0;
    start_c = 0; lr_c = 0; lbl_c = 0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (busy_a !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy_a); else pass++;
    total++; if (done_a !== 1'b0) $display("FAIL rst_done got %0b want 0", done_a); else pass++;
    total++; if (ir_a !== 1'b0) $display("FAIL rst_image_ready got %0b want 0", ir_a); else pass++;
    total++; if (pix_a !== '0) $display("FAIL rst_pixels got %0h want 0", pix_a); else pass++;
    total++; if (addr_a !== 5'd0) $display("FAIL rst_rom_addr got %0d want 0", addr_a); else pass++;
    total++; if (img_a !== 1'd0) $display("FAIL rst_image_num got %0d want 0", img_a); else pass++;
    total++; if (cor_a !== 2'd0) $display("FAIL rst_correct got %0d want 0", cor_a); else pass++;
    total++; if (to_a !== 2'd0) $display("FAIL rst_timeout got %0d want 0", to_a); else pass++;
    total++; if (pix_b !== '0) $display("FAIL rst_pixels_b got %0h want 0", pix_b); else pass++;
    total++; if (busy_c !== 1'b0) $display("FAIL rst_busy_c got %0b want 0", busy_c); else pass++;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_stream_a();
    int e_ir, e_busy, e_pix, e_addr;
    start_a = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      start_a = 1'b0;
      lr_a = 1'b0;
      e_ir = (c == 1 || c == 15) ? 1 : 0;
      e_busy = (c >= 1 && c <= 28) ? 1 : 0;
      e_pix = 0;
      if (c >= 2 && c <= 11) e_pix = c - 2;
      if (c >= 16 && c <= 25) e_pix = c - 6;
      e_addr = -1;
      if (c == 1) e_addr = 0;
      if (c >= 2 && c <= 11) e_addr = c - 1;
      if (c == 15) e_addr = 10;
      if (c >= 16 && c <= 25) e_addr = c - 5;
      total++; if (ir_a !== 1'(e_ir)) $display("FAIL a_image_ready c=%0d got %0b want %0d", c, ir_a, e_ir); else pass++;
      total++; if (busy_a !== 1'(e_busy)) $display("FAIL a_busy c=%0d got %0b want %0d", c, busy_a, e_busy); else pass++;
      total++; if (pix_a[0] !== 16'(e_pix)) $display("FAIL a_pixels c=%0d got %0d want %0d", c, pix_a[0], e_pix); else pass++;
      if (e_addr >= 0) begin
        total++; if (addr_a !== 5'(e_addr)) $display("FAIL a_rom_addr c=%0d got %0d want %0d", c, addr_a, e_addr); else pass++;
      end
      if (c == 5) begin lr_a = 1'b1; lbl_a = 4'd3; end
      if (c == 13) begin lr_a = 1'b1; lbl_a = 4'd3; end
      if (c == 27) begin lr_a = 1'b1; lbl_a = 4'd4; end
    end
    total++; if (done_a !== 1'b1) $display("FAIL a_done got %0b want 1", done_a); else pass++;
    total++; if (cor_a !== 2'd2) $display("FAIL a_correct got %0d want 2", cor_a); else pass++;
    total++; if (to_a !== 2'd0) $display("FAIL a_timeout got %0d want 0", to_a); else pass++;
    total++; if (img_a !== 1'd1) $display("FAIL a_image_num_held got %0d want 1", img_a); else pass++;
  endtask

  task automatic test_chunks_b();
    logic [63:0] e_pix;
    int e_ir, e_addr;
    start_b = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      start_b = 1'b0;
      lr_b = 1'b0;
      e_ir = (c == 1 || c == 8) ? 1 : 0;
      e_pix = '0;
      if (c >= 2 && c <= 3) e_pix = lanes4(c - 2, 4);
      if (c == 4) e_pix = lanes4(2, 2);
      if (c >= 9 && c <= 10) e_pix = lanes4(c - 6, 4);
      if (c == 11) e_pix = lanes4(5, 2);
      e_addr = -1;
      if (c >= 1 && c <= 4) e_addr = c - 1;
      if (c >= 8 && c <= 11) e_addr = c - 5;
      total++; if (ir_b !== 1'(e_ir)) $display("FAIL b_image_ready c=%0d got %0b want %0d", c, ir_b, e_ir); else pass++;
      total++; if (pix_b !== e_pix) $display("FAIL b_pixels c=%0d got %h want %h", c, pix_b, e_pix); else pass++;
      if (e_addr >= 0) begin
        total++; if (addr_b !== 3'(e_addr)) $display("FAIL b_rom_addr c=%0d got %0d want %0d", c, addr_b, e_addr); else pass++;
      end
      if (c == 5) begin
        total++; if (cor_b !== 2'd0) $display("FAIL b_stray_label got %0d want 0", cor_b); else pass++;
      end
      if (c == 7) begin
        total++; if (cor_b !== 2'd1) $display("FAIL b_first_label got %0d want 1", cor_b); else pass++;
      end
      if (c == 3) begin lr_b = 1'b1; lbl_b = 4'd5; end
      if (c == 6) begin lr_b = 1'b1; lbl_b = 4'd5; end
      if (c == 13) begin lr_b = 1'b1; lbl_b = 4'd0; end
    end
    total++; if (cor_b !== 2'd1) $display("FAIL b_correct got %0d want 1", cor_b); else pass++;
    total++; if (to_b !== 2'd0) $display("FAIL b_timeout got %0d want 0", to_b); else pass++;
    total++; if (done_b !== 1'b1) $display("FAIL b_done got %0b want 1", done_b); else pass++;
  endtask

  task automatic test_timeout_c();
    int e_ir, e_busy;
    start_c = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      cyc();
      start_c = 1'b0;
      e_ir = (c == 1 || c == 21 || c == 41) ? 1 : 0;
      e_busy = (c >= 1 && c <= 60) ? 1 : 0;
      total++; if (ir_c !== 1'(e_ir)) $display("FAIL c_image_ready c=%0d got %0b want %0d", c, ir_c, e_ir); else pass++;
      total++; if (busy_c !== 1'(e_busy)) $display("FAIL c_busy c=%0d got %0b want %0d", c, busy_c, e_busy); else pass++;
      total++; if (done_c !== 1'(c >= 61)) $display("FAIL c_done c=%0d got %0b", c, done_c); else pass++;
      if (c >= 2 && c <= 11) begin
        total++; if (pix_c[0] !== 16'(c - 2)) $display("FAIL c_pixels c=%0d got %0d want %0d", c, pix_c[0], c - 2); else pass++;
      end
      if (c == 20) begin
        total++; if (to_c !== 2'd1) $display("FAIL c_timeout_1 got %0d want 1", to_c); else pass++;
      end
      if (c == 40) begin
        total++; if (to_c !== 2'd2) $display("FAIL c_timeout_2 got %0d want 2", to_c); else pass++;
      end
    end
    total++; if (to_c !== 2'd3) $display("FAIL c_timeout got %0d want 3", to_c); else pass++;
    total++; if (cor_c !== 2'd0) $display("FAIL c_correct got %0d want 0", cor_c); else pass++;
  endtask

  task automatic test_start_busy_coincide();
    int e_ir;
    start_c = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      cyc();
      start_c = (c == 14);
      lr_c = 1'b0;
      e_ir = (c == 1 || c == 21 || c == 41) ? 1 : 0;
      total++; if (ir_c !== 1'(e_ir)) $display("FAIL d_image_ready c=%0d got %0b want %0d", c, ir_c, e_ir); else pass++;
      if (c == 1) begin
        total++; if (to_c !== 2'd0) $display("FAIL d_restart_timeout got %0d want 0", to_c); else pass++;
        total++; if (img_c !== 2'd0) $display("FAIL d_restart_image got %0d want 0", img_c); else pass++;
      end
      if (c == 16) begin
        total++; if (img_c !== 2'd0) $display("FAIL d_start_ignored got %0d want 0", img_c); else pass++;
      end
      if (c == 20) begin
        total++; if (cor_c !== 2'd1) $display("FAIL d_coincide_correct got %0d want 1", cor_c); else pass++;
        total++; if (to_c !== 2'd0) $display("FAIL d_coincide_timeout got %0d want 0", to_c); else pass++;
      end
      if (c == 19) begin lr_c = 1'b1; lbl_c = 4'd1; end
    end
    total++; if (cor_c !== 2'd1) $display("FAIL d_correct got %0d want 1", cor_c); else pass++;
    total++; if (to_c !== 2'd2) $display("FAIL d_timeout got %0d want 2", to_c); else pass++;
    total++; if (done_c !== 1'b1) $display("FAIL d_done got %0b want 1", done_c); else pass++;
  endtask

  task automatic test_reset_mid();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    repeat (4) cyc();
    total++; if (pix_a[0] !== 16'd3) $display("FAIL m_pre_reset_pixels got %0d want 3", pix_a[0]); else pass++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (busy_a !== 1'b0) $display("FAIL m_reset_busy got %0b want 0", busy_a); else pass++;
    total++; if (pix_a !== '0) $display("FAIL m_reset_pixels got %0d want 0", pix_a[0]); else pass++;
    total++; if (addr_a !== 5'd0) $display("FAIL m_reset_addr got %0d want 0", addr_a); else pass++;
    reset = 1'b0;
    cyc();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    total++; if (ir_a !== 1'b1) $display("FAIL m_replay_ready got %0b want 1", ir_a); else pass++;
    total++; if (addr_a !== 5'd0) $display("FAIL m_replay_addr0 got %0d want 0", addr_a); else pass++;
    cyc();
    total++; if (addr_a !== 5'd1) $display("FAIL m_replay_addr1 got %0d want 1", addr_a); else pass++;
    cyc();
    total++; if (pix_a[0] !== 16'd1) $display("FAIL m_replay_pixels got %0d want 1", pix_a[0]); else pass++;
    total++; if (img_a !== 1'd0) $display("FAIL m_replay_image got %0d want 0", img_a); else pass++;
  endtask

  initial begin
    pass = 0;
    total = 0;
    test_reset();
    test_stream_a();
    test_chunks_b();
    test_timeout_c();
    test_start_busy_coincide();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
